// File: rtl/boot_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them to instruction memory, then releases the core.
// Optional trailing XOR checksum byte is enabled by defining BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 256,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [31:0] instr_word,
    output logic        i_wr_e,
    output logic [31:0] wr_addr,
    output logic [31:0] pc_rst_vec,
    output logic        core_rst_n,
    output logic [15:0] words_loaded,
    output logic        done,
    output logic        error
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd6;
    localparam logic [2:0] S_LAST  = S_CHK;
`else
    localparam logic [2:0] S_LAST  = S_DONE;
`endif

    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   MAX_N   = 32'(MAX_WORDS);

    logic [2:0]    r_state;
    logic [1:0]    r_byte_idx;
    logic [23:0]   r_asm;
    logic [31:0]   r_count;
    logic [15:0]   r_words;
    logic [31:0]   r_instr;
    logic [31:0]   r_addr;
    logic [TW-1:0] r_idle;
    logic          r_armed;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]    r_xor;
`endif

    logic        w_accept;
    logic [31:0] w_word;
    logic        w_timeout;
    logic        w_more;

`ifdef BOOT_LOADER_CHECKSUM_EN
    assign byte_ready = (r_state == S_HDR) || (r_state == S_LOAD) || (r_state == S_CHK);
`else
    assign byte_ready = (r_state == S_HDR) || (r_state == S_LOAD);
`endif
    assign w_accept  = byte_valid && byte_ready;
    // Incoming byte lands on top; after four bytes the first one sits in [7:0].
    assign w_word    = {byte_data, r_asm};
    assign w_timeout = r_armed && byte_ready && !w_accept && (r_idle == TO_LAST);
    assign w_more    = ({16'd0, r_words} + 32'd1) < r_count;

    assign i_wr_e       = (r_state == S_WRITE);
    assign instr_word   = r_instr;
    assign wr_addr      = r_addr;
    assign pc_rst_vec   = BASE_ADDR;
    assign core_rst_n   = (r_state == S_DONE);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERR);
    assign words_loaded = r_words;

    // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge register values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_byte_idx <= 2'd0;
            r_asm      <= 24'd0;
            r_count    <= 32'd0;
            r_words    <= 16'd0;
            r_instr    <= 32'd0;
            r_addr     <= BASE_ADDR;
            r_idle     <= '0;
            r_armed    <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_xor      <= 8'd0;
`endif
        end else if (start) begin
            r_state    <= S_HDR;
            r_byte_idx <= 2'd0;
            r_asm      <= 24'd0;
            r_count    <= 32'd0;
            r_words    <= 16'd0;
            r_idle     <= '0;
            r_armed    <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_xor      <= 8'd0;
`endif
        end else begin
            // Idle timer only runs once the first header byte has arrived.
            if (w_accept) begin
                r_idle  <= '0;
                r_armed <= 1'b1;
            end else if (byte_ready && r_armed) begin
                r_idle <= r_idle + 1'b1;
            end

            case (r_state)
                S_HDR: begin
                    if (w_timeout) begin
                        r_state <= S_ERR;
                    end else if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_asm      <= w_word[31:8];
                        if (r_byte_idx == 2'd3) begin
                            r_count <= w_word;
                            r_state <= ((w_word == 32'd0) || (w_word > MAX_N)) ? S_ERR : S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_timeout) begin
                        r_state <= S_ERR;
                    end else if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_asm      <= w_word[31:8];
`ifdef BOOT_LOADER_CHECKSUM_EN
                        r_xor      <= r_xor ^ byte_data;
`endif
                        if (r_byte_idx == 2'd3) begin
                            r_instr <= w_word;
                            r_addr  <= BASE_ADDR + {14'd0, r_words, 2'b00};
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_words <= r_words + 16'd1;
                    r_state <= w_more ? S_LOAD : S_LAST;
                end
`ifdef BOOT_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_timeout) begin
                        r_state <= S_ERR;
                    end else if (w_accept) begin
                        r_state <= (byte_data == r_xor) ? S_DONE : S_ERR;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
